// File: rtl/attex_bus_pkg.sv
// attex_bus_pkg
// Shared types and constants for the SCC68070 ATTEX bus matrix.
//   attex_state_e  : transaction state machine encoding
//   attex_region_t : one address region {base, mask}
//   REGION_*       : default CD-i memory map regions
//   DEFAULT_REGION_BASE / DEFAULT_REGION_MASK : packed five-slave default map
//   region_match() : masked address compare used by the decoder
package attex_bus_pkg;

    localparam int ATTEX_DATA_W = 16;
    localparam int ATTEX_ADDR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERR
    } attex_state_e;

    typedef struct packed {
        logic [ATTEX_ADDR_W-1:0] base;
        logic [ATTEX_ADDR_W-1:0] mask;
    } attex_region_t;

    // MCD212 video RAM occupies the bottom 2 MB; the others are 64 KB / 1 MB windows.
    localparam attex_region_t REGION_MCD212 = '{base: 24'h000000, mask: 24'hE00000};
    localparam attex_region_t REGION_CDIC   = '{base: 24'h300000, mask: 24'hFF0000};
    localparam attex_region_t REGION_SLAVE  = '{base: 24'h310000, mask: 24'hFF0000};
    localparam attex_region_t REGION_MK48   = '{base: 24'h320000, mask: 24'hFF0000};
    localparam attex_region_t REGION_DVC    = '{base: 24'hD00000, mask: 24'hF00000};

    // Slave 0 sits in the lowest slice of the packed arrays.
    localparam logic [5*ATTEX_ADDR_W-1:0] DEFAULT_REGION_BASE = {
        REGION_DVC.base, REGION_MK48.base, REGION_SLAVE.base,
        REGION_CDIC.base, REGION_MCD212.base};
    localparam logic [5*ATTEX_ADDR_W-1:0] DEFAULT_REGION_MASK = {
        REGION_DVC.mask, REGION_MK48.mask, REGION_SLAVE.mask,
        REGION_CDIC.mask, REGION_MCD212.mask};

    function automatic logic region_match(input logic [ATTEX_ADDR_W-1:0] a,
                                          input logic [ATTEX_ADDR_W-1:0] base,
                                          input logic [ATTEX_ADDR_W-1:0] mask);
        return (a & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/attex_bus_matrix_region_decode.sv
// attex_region_decode
// Combinational priority address decoder: the lowest-indexed matching region wins.
//   addr  in  : 24-bit byte address
//   hit   out : some region matched
//   index out : index of the winning region (0 when no hit)
module attex_region_decode
    import attex_bus_pkg::*;
#(
    parameter int                               NUM_SLAVES  = 5,
    parameter int                               IDX_W       = 3,
    parameter logic [NUM_SLAVES*ATTEX_ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ATTEX_ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK
) (
    input  logic [ATTEX_ADDR_W-1:0] addr,
    output logic                    hit,
    output logic [IDX_W-1:0]        index
);

    // Scanning from the top down lets lower indices overwrite higher ones.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region_match(addr,
                             REGION_BASE[i*ATTEX_ADDR_W +: ATTEX_ADDR_W],
                             REGION_MASK[i*ATTEX_ADDR_W +: ATTEX_ADDR_W])) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/attex_bus_matrix.sv
// attex_bus_matrix
// CPU-side bus matrix for the SCC68070 ATTEX bus: programmable regions,
// registered one-hot chip selects, per-slave level/edge acknowledge,
// unmapped-address bus error and an optional watchdog.
// Build option: define ATTEX_BUS_TIMEOUT_EN to include the watchdog timer.
// Ports:
//   clk30, reset        : clock, synchronous active-high reset
//   as, uds, lds        : CPU address / data strobes
//   write_strobe        : CPU write cycle (reads and writes are handled alike)
//   addr[23:1]          : CPU word address
//   slave_dout          : packed slave read data, slave i at [16i+15:16i]
//   slave_ack           : per-slave acknowledge
//   slave_cs            : registered one-hot chip select
//   data_in             : registered read data to the CPU
//   bus_ack, bus_err    : cycle complete / bus error to the CPU
//   busy                : a transaction is in progress
module attex_bus_matrix
    import attex_bus_pkg::*;
#(
    parameter int                                 NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*ATTEX_ADDR_W-1:0] REGION_BASE    = DEFAULT_REGION_BASE,
    parameter logic [NUM_SLAVES*ATTEX_ADDR_W-1:0] REGION_MASK    = DEFAULT_REGION_MASK,
    parameter logic [NUM_SLAVES-1:0]              ACK_EDGE       = '0,
    parameter int                                 TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk30,
    input  logic                                 reset,
    input  logic                                 as,
    input  logic                                 uds,
    input  logic                                 lds,
    input  logic                                 write_strobe,
    input  logic [23:1]                          addr,
    input  logic [ATTEX_DATA_W*NUM_SLAVES-1:0]   slave_dout,
    input  logic [NUM_SLAVES-1:0]                slave_ack,
    output logic [NUM_SLAVES-1:0]                slave_cs,
    output logic [ATTEX_DATA_W-1:0]              data_in,
    output logic                                 bus_ack,
    output logic                                 bus_err,
    output logic                                 busy
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    attex_state_e              state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_SLAVES-1:0]     cs_q, cs_d;
    logic [ATTEX_DATA_W-1:0]   data_q, data_d;
    logic                      ack_out_q, ack_out_d;
    logic                      err_q, err_d;
    logic [NUM_SLAVES-1:0]     ack_hist_q;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_index;
    logic                      request;
    logic                      eff_ack;
    logic                      timeout_hit;
    logic                      unused_write;

    assign unused_write = write_strobe;
    assign request      = as && (uds || lds);

    attex_region_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .addr  ({addr, 1'b0}),
        .hit   (dec_hit),
        .index (dec_index)
    );

    // Edge-mode slaves only count a low-to-high transition of their ack line.
    assign eff_ack = slave_ack[idx_q] & ~(ACK_EDGE[idx_q] & ack_hist_q[idx_q]);

`ifdef ATTEX_BUS_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        timer_clear;

    assign timeout_hit = (timer_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timer_d = timer_q;
        if (timer_clear) begin
            timer_d = '0;
        end else if (state_q == ST_WAIT_ACK && timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic          timer_clear;
    logic          unused_timer_clear;

    assign timeout_hit        = 1'b0;
    assign unused_timer_clear = timer_clear;
`endif

    // Next-state and output logic; ack beats abort, abort beats timeout.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cs_d        = cs_q;
        data_d      = data_q;
        ack_out_d   = ack_out_q;
        err_d       = err_q;
        timer_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (request) begin
                    if (dec_hit) begin
                        idx_d            = dec_index;
                        cs_d             = '0;
                        cs_d[dec_index]  = 1'b1;
                        timer_clear      = 1'b1;
                        state_d          = ST_WAIT_ACK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (eff_ack) begin
                    data_d    = slave_dout[int'(idx_q)*ATTEX_DATA_W +: ATTEX_DATA_W];
                    cs_d      = '0;
                    ack_out_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (!as) begin
                    cs_d    = '0;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    cs_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                if (!as) begin
                    ack_out_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (!as) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cs_q       <= '0;
            data_q     <= '0;
            ack_out_q  <= 1'b0;
            err_q      <= 1'b0;
            ack_hist_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
            ack_out_q  <= ack_out_d;
            err_q      <= err_d;
            ack_hist_q <= slave_ack;
        end
    end

    assign slave_cs = cs_q;
    assign data_in  = data_q;
    assign bus_ack  = ack_out_q;
    assign bus_err  = err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
